alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port round-robin arbiter that time-shares a single `yAlu` instance between two requesters, e.g. the integer pipeline and the address-generation path. Each port has a valid/ready request channel (operands plus 3-bit ALU op) and a valid/ready response channel (32-bit result plus zero flag). The block owns the ALU instance, registers operands and result, and serves one operation at a time.

## Interface
- `WIDTH`, 32, operand/result width; must equal the `yAlu` width (32); other values unsupported.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  port 0 request valid.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `req0_a`, `req0_b`  in  WIDTH  port 0 operands (signed two's complement).
- `req0_op`  in  3  port 0 ALU op.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as port 0, for port 1.
- `rsp0_valid`  out  1  port 0 result valid.
- `rsp0_ready`  in  1  port 0 consumer accepts result.
- `rsp0_z`  out  WIDTH  port 0 result.
- `rsp0_zero`  out  1  1 when `rsp0_z` == 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_z`, `rsp1_zero`: same as port 0, for port 1.

## Operation
- ALU op encoding:
  - 0/4: AND
  - 1/5: OR
  - 2: a+b
  - 6: a−b
  - 3/7: result 0
- Arithmetic wraps modulo 2^32; no overflow or carry output.
- FSM states: IDLE, EXEC, RESP. Registers:
  - `op_a`, `op_b`, `op_code`: latched operands.
  - `owner`: 1 bit, port being served.
  - `last`: 1 bit, last port granted.
  - `res_z`, `res_zero`: latched result.
- IDLE grant:
  - Only one valid: that port wins.
  - Both valid: the port ≠ `last` wins.
  - Neither valid: stay in IDLE.
- `reqN_ready` = (state==IDLE) && grant==N. This is a combinational valid→ready path. At most one ready is high per cycle.
- On accept (`reqN_valid && reqN_ready`): latch operands, `owner`=N, `last`=N, go to EXEC.
- EXEC: ALU is driven from the latched registers. Capture `res_z` = ALU z and `res_zero` = (ALU z == 0). Go to RESP.
- RESP:
  - `rsp<owner>_valid`=1; the other port's `rsp_valid`=0.
  - `rsp*_z` / `rsp*_zero` of the owner show `res_z` / `res_zero`; non-owner outputs read 0.
  - On `rsp<owner>_ready`: go to IDLE.
  - While ready is low: hold all outputs stable indefinitely. No new request is accepted.
- Requesters must hold `reqN_*` stable while valid && !ready. A request is never dropped. Valid may deassert only after acceptance.
- Input changes after acceptance do not affect the in-flight result.
- `rspN_ready` asserted while `rspN_valid`=0 is ignored.

## Timing
- Reset (`rst_n`=0, any time, asynchronous):
  - state=IDLE, `last`=1, so port 0 wins the first contention.
  - `owner`=0; `op_*`, `res_z`=0, `res_zero`=0.
  - All `rsp*_valid`=0, all `rsp*_z`=0, all `rsp*_zero`=0.
  - Both `req*_ready` forced 0 while `rst_n`=0.
- Reset mid-EXEC or mid-RESP aborts the operation. No response is produced, and the requester must re-issue.
- Accept at edge N → EXEC during cycle N..N+1 → result latched at edge N+1.
- `rsp_valid` is high from edge N+1 onward.
- Earliest consume is edge N+2. The next accept is at edge N+3 at the earliest, so throughput is 1 op / 3 cycles.
- Both ports valid continuously gives strict alternation 0,1,0,1…, with no starvation.
- Request arriving in the same cycle as a response is consumed: it is not accepted until the cycle after return to IDLE.

## Test plan
- Reset release, then `req0` a=5, b=3, op=2 → `req0_ready`=1 same cycle; `rsp0_valid` high after 2nd edge with `rsp0_z`=8, `rsp0_zero`=0; `rsp1_valid` stays 0.
- `req1` a=3, b=5, op=6 → `rsp1_z`=0xFFFFFFFE. Then a=0xF0F0F0F0, b=0x0FF00FF0, op=4 → `rsp1_z`=0x00F000F0. Then same operands with op=5 → `rsp1_z`=0xFFF0FFF0.
- Both valid from reset, each with 3 queued ops → grant order 0,1,0,1,0,1; each result routed to the correct port only.
- Op 3 and op 7 with a=0xFFFFFFFF, b=1 → z=0, zero=1. Op 2 with a=0x7FFFFFFF, b=1 → z=0x80000000 (wrap, no error).
- `rsp0_ready` held low 5 cycles while `req1_valid`=1 → `rsp0` outputs stable and `req1_ready`=0 throughout. Raise ready → `req1` accepted at the first IDLE cycle.
- Assert `rst_n`=0 during EXEC of a port-0 op → all valids/readies 0 immediately, no `rsp0`. After release with both ports valid, port 0 is granted first.

Source files
------------

// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter time-sharing one yAlu; one operation in flight,
// operands and result registered, fair alternation under contention.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_z,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_z,
  output logic             rsp1_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } req_t;

  state_t           state;
  logic             owner, last;
  logic [WIDTH-1:0] op_a, op_b, res_z, alu_z;
  logic [2:0]       op_code;
  logic             res_zero;
  logic             gnt, idle, accept, owner_rdy;
  req_t             req_sel;
  logic [1:0]       rsp_valid;
  logic [1:0][WIDTH-1:0] rsp_z;
  logic [1:0]       rsp_zero;

  // Port 1 wins when alone, or when both contend and port 0 went last.
  assign gnt        = req1_valid && (!req0_valid || !last);
  assign idle       = rst_n && (state == IDLE);
  assign req0_ready = idle && req0_valid && !gnt;
  assign req1_ready = idle && req1_valid && gnt;
  assign accept     = req0_ready || req1_ready;
  assign req_sel    = gnt ? req_t'{req1_a, req1_b, req1_op} : req_t'{req0_a, req0_b, req0_op};
  assign owner_rdy  = owner ? rsp1_ready : rsp0_ready;

  yAlu #(.WIDTH(WIDTH)) u_alu (
    .a  (op_a),
    .b  (op_b),
    .op (op_code),
    .z  (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      res_z    <= '0;
      res_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a    <= req_sel.a;
          op_b    <= req_sel.b;
          op_code <= req_sel.op;
          owner   <= gnt;
          last    <= gnt;
          state   <= EXEC;
        end
        EXEC: begin
          res_z    <= alu_z;
          res_zero <= (alu_z == '0);
          state    <= RESP;
        end
        RESP: if (owner_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Only the owner sees the result; the other port reads zero.
  for (genvar p = 0; p < 2; p++) begin : g_rsp
    assign rsp_valid[p] = (state == RESP) && (owner == 1'(p));
    assign rsp_z[p]     = rsp_valid[p] ? res_z : '0;
    assign rsp_zero[p]  = rsp_valid[p] && res_zero;
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_z     = rsp_z[0];
  assign rsp1_z     = rsp_z[1];
  assign rsp0_zero  = rsp_zero[0];
  assign rsp1_zero  = rsp_zero[1];
endmodule

// Shared ALU: bitwise, add/sub (wrapping) and a constant-zero op.
module yAlu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z
);
  always_comb begin
    z = '0;
    case (op)
      3'd0, 3'd4: z = a & b;
      3'd1, 3'd5: z = a | b;
      3'd2:       z = a + b;
      3'd6:       z = a - b;
      default:    z = '0;
    endcase
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed plus randomized bench for alu_share_arb with a transaction-level
// reference model (per-port request queues, grant rule, ALU function).
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_z, rsp1_z;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } op_t;

  op_t q0[$], q1[$];
  int  last_m;
  int  checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z), .rsp1_zero(rsp1_zero)
  );

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0, 3'd4: return a & b;
      3'd1, 3'd5: return a | b;
      3'd2:       return a + b;
      3'd6:       return a - b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    op_t o;
    o.a = a; o.b = b; o.op = op;
    return o;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present each requester's queue head; requesters hold until accepted.
  task automatic drive();
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    if (q0.size() != 0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op; end
    if (q1.size() != 0) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op; end
  endtask

  // One complete transaction: grant, exec cycle, response held for 'hold' cycles, consume.
  task automatic serve(input int hold, input bit first);
    int w, n;
    op_t o;
    logic [31:0] ez;
    drive();
    #1;
    w = (q0.size() != 0 && q1.size() != 0) ? (last_m == 1 ? 0 : 1) : (q0.size() != 0 ? 0 : 1);
    n = 0;
    while (!(req0_ready || req1_ready) && n < 8) begin
      @(posedge clk); #1; n++;
    end
    check("grant", 32'({req1_ready, req0_ready}), (w == 1) ? 32'd2 : 32'd1);
    if (!first) check("accept_latency", 32'(n), 32'd0);
    o = (w == 1) ? q1.pop_front() : q0.pop_front();
    ez = alu_ref(o.op, o.a, o.b);
    @(posedge clk); #1;
    last_m = w;
    drive();
    check("exec_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i <= hold; i++) begin
      check("rsp_valid", 32'({rsp1_valid, rsp0_valid}), (w == 1) ? 32'd2 : 32'd1);
      check("rsp_z", (w == 1) ? rsp1_z : rsp0_z, ez);
      check("rsp_zero", 32'((w == 1) ? rsp1_zero : rsp0_zero), 32'(ez == 32'd0));
      check("other_z", (w == 1) ? rsp0_z : rsp1_z, 32'd0);
      check("busy_ready", 32'({req1_ready, req0_ready}), 32'd0);
      if (i < hold) begin
        rsp0_ready = (w == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        rsp1_ready = (w == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end
    end
    rsp0_ready = (w == 0);
    rsp1_ready = (w == 1);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check("consumed", 32'({rsp1_valid, rsp0_valid}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    last_m = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("rst_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("rst_z", rsp0_z | rsp1_z, 32'd0);
    check("rst_zero", 32'({rsp1_zero, rsp0_zero}), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    // Basic add on port 0.
    q0.push_back(mk(32'd5, 32'd3, 3'd2));
    serve(0, 1'b1);

    // Subtract and bitwise ops on port 1.
    q1.push_back(mk(32'd3, 32'd5, 3'd6));
    q1.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4));
    q1.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd5));
    repeat (3) serve(0, 1'b0);

    // Contention: three ops queued on each port.
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk($urandom, $urandom, 3'($urandom_range(0, 7))));
      q1.push_back(mk($urandom, $urandom, 3'($urandom_range(0, 7))));
    end
    repeat (6) serve(0, 1'b0);

    // Zero ops and wrap.
    q0.push_back(mk(32'hFFFF_FFFF, 32'd1, 3'd3));
    q0.push_back(mk(32'hFFFF_FFFF, 32'd1, 3'd7));
    q0.push_back(mk(32'h7FFF_FFFF, 32'd1, 3'd2));
    repeat (3) serve(0, 1'b0);

    // Back-pressure on port 0 while port 1 waits.
    q1.push_back(mk(32'd9, 32'd9, 3'd6));
    serve(0, 1'b0);
    q0.push_back(mk(32'h1234_5678, 32'h0000_0001, 3'd2));
    q1.push_back(mk(32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'd1));
    serve(5, 1'b0);
    serve(0, 1'b0);

    // Reset during EXEC aborts the operation.
    q0.push_back(mk(32'd7, 32'd7, 3'd2));
    drive();
    #1;
    check("pre_abort_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    void'(q0.pop_front());
    rst_n = 1'b0;
    q0.push_back(mk(32'd11, 32'd4, 3'd6));
    q1.push_back(mk(32'd2, 32'd2, 3'd2));
    drive();
    #1;
    check("abort_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("abort_ready", 32'({req1_ready, req0_ready}), 32'd0);
    @(posedge clk); #1;
    check("abort_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    rst_n = 1'b1;
    last_m = 1;
    serve(0, 1'b1);
    serve(0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) q0.push_back(mk(rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7))));
      if ($urandom_range(0, 1) == 1) q1.push_back(mk(rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7))));
      if (q0.size() == 0 && q1.size() == 0) q1.push_back(mk(rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7))));
      serve(int'($urandom_range(0, 3)), 1'b0);
    end
    while (q0.size() != 0 || q1.size() != 0) serve(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
